// File: rtl/jtdd_vrom_resp.sv
// jtdd_vrom_resp: serves char/scroll/object video ROM ports from one 16-bit memory read port,
// caching the last word fetched per port and refetching whenever a port's tag stops matching.
module jtdd_vrom_resp #(
    parameter int CHAR_AW = 15,
    parameter int SCR_AW = 17,
    parameter int OBJ_AW = 18,
    parameter int MEM_AW = 22,
    parameter logic [MEM_AW-1:0] CHAR_OFFSET = '0,
    parameter logic [MEM_AW-1:0] SCR_OFFSET = '0,
    parameter logic [MEM_AW-1:0] OBJ_OFFSET = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CHAR_AW-1:0] char_addr,
    output logic [7:0]        char_data,
    output logic              char_ok,
    input  logic [SCR_AW-1:0] scr_addr,
    output logic [15:0]       scr_data,
    output logic              scr_ok,
    input  logic [OBJ_AW-1:0] obj_addr,
    output logic [15:0]       obj_data,
    output logic              obj_ok,
    output logic              mem_req,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [15:0]       mem_dout,
    input  logic              mem_rdy
);
    localparam int AB = SCR_AW > CHAR_AW - 1 ? SCR_AW : CHAR_AW - 1;
    localparam int TW = OBJ_AW > AB ? OBJ_AW : AB;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    typedef enum logic [1:0] {P_CHAR, P_SCR, P_OBJ} port_t;
    state_t st;
    port_t sel;
    logic [TW-1:0] cap_tag;
    logic [CHAR_AW-2:0] char_tag;
    logic [SCR_AW-1:0] scr_tag;
    logic [OBJ_AW-1:0] obj_tag;
    logic [15:0] char_word;
    logic char_vld, scr_vld, obj_vld;
    logic done;
    assign char_ok = char_vld && char_tag == char_addr[CHAR_AW-1:1];
    assign scr_ok = scr_vld && scr_tag == scr_addr;
    assign obj_ok = obj_vld && obj_tag == obj_addr;
    assign char_data = char_addr[0] ? char_word[15:8] : char_word[7:0];
    // rdy seen in REQ completes even without ack, so late-ack controllers still finish
    assign done = mem_rdy && (st == REQ || st == WAIT);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= IDLE;
            sel <= P_CHAR;
            cap_tag <= '0;
            mem_req <= 1'b0;
            mem_addr <= '0;
            char_tag <= '0;
            scr_tag <= '0;
            obj_tag <= '0;
            char_word <= '0;
            scr_data <= '0;
            obj_data <= '0;
            char_vld <= 1'b0;
            scr_vld <= 1'b0;
            obj_vld <= 1'b0;
        end else begin
            case (st)
                IDLE: if (!char_ok || !scr_ok || !obj_ok) begin
                    mem_req <= 1'b1;
                    st <= REQ;
                    sel <= !char_ok ? P_CHAR : !scr_ok ? P_SCR : P_OBJ;
                    cap_tag <= !char_ok ? TW'(char_addr[CHAR_AW-1:1]) :
                               !scr_ok ? TW'(scr_addr) : TW'(obj_addr);
                    mem_addr <= !char_ok ? CHAR_OFFSET + MEM_AW'(char_addr[CHAR_AW-1:1]) :
                                !scr_ok ? SCR_OFFSET + MEM_AW'(scr_addr) :
                                OBJ_OFFSET + MEM_AW'(obj_addr);
                end
                REQ: if (mem_ack || mem_rdy) begin
                    mem_req <= 1'b0;
                    st <= mem_rdy ? IDLE : WAIT;
                end
                WAIT: if (mem_rdy) st <= IDLE;
                default: st <= IDLE;
            endcase
            if (done && sel == P_CHAR) begin
                char_tag <= cap_tag[CHAR_AW-2:0];
                char_word <= mem_dout;
                char_vld <= 1'b1;
            end
            if (done && sel == P_SCR) begin
                scr_tag <= cap_tag[SCR_AW-1:0];
                scr_data <= mem_dout;
                scr_vld <= 1'b1;
            end
            if (done && sel == P_OBJ) begin
                obj_tag <= cap_tag[OBJ_AW-1:0];
                obj_data <= mem_dout;
                obj_vld <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_jtdd_vrom_resp.sv
// tb_jtdd_vrom_resp: directed stimulus; expected request addresses queued and checked by a monitor.
module tb_jtdd_vrom_resp;
    logic clk = 0, rst_n = 0;
    logic [14:0] char_addr = 0;
    logic [16:0] scr_addr = 0;
    logic [17:0] obj_addr = 0;
    logic [7:0] char_data;
    logic [15:0] scr_data, obj_data, mem_dout = 0;
    logic char_ok, scr_ok, obj_ok, mem_req, mem_ack = 0, mem_rdy = 0;
    logic [21:0] mem_addr, last_addr = 0;
    logic req_d = 0;
    int checks = 0, fails = 0;
    logic [21:0] exp_q[$];

    jtdd_vrom_resp #(.SCR_OFFSET(22'h8000)) dut (
        .clk(clk), .rst_n(rst_n),
        .char_addr(char_addr), .char_data(char_data), .char_ok(char_ok),
        .scr_addr(scr_addr), .scr_data(scr_data), .scr_ok(scr_ok),
        .obj_addr(obj_addr), .obj_data(obj_data), .obj_ok(obj_ok),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_dout(mem_dout), .mem_rdy(mem_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: each new request must match the next queued address and stay stable until dropped
    always @(negedge clk) begin
        if (!rst_n) req_d = 0;
        else begin
            if (mem_req && !req_d) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL req_unexpected: got addr %h expected no request", mem_addr);
                end else chk("req_addr", 32'(mem_addr), 32'(exp_q.pop_front()));
            end else if (mem_req) chk("addr_stable", 32'(mem_addr), 32'(last_addr));
            req_d = mem_req;
            last_addr = mem_addr;
        end
    end

    task automatic wait_req();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req && n < 50);
        if (!mem_req) begin
            checks++;
            fails++;
            $display("FAIL req_timeout: got mem_req 0 expected 1 within 50 cycles");
        end
    endtask

    task automatic serve(input int dly, input logic [15:0] d);
        wait_req();
        repeat (dly) begin
            @(negedge clk);
            chk("req_hold", 32'(mem_req), 1);
        end
        mem_ack = 1;
        mem_rdy = 1;
        mem_dout = d;
        @(negedge clk);
        mem_ack = 0;
        mem_rdy = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1);
    end

    initial begin
        // reset with all addresses 0, then char, scroll, object fetched in priority order
        repeat (2) @(negedge clk);
        chk("rst_char_ok", 32'(char_ok), 0);
        chk("rst_scr_ok", 32'(scr_ok), 0);
        chk("rst_obj_ok", 32'(obj_ok), 0);
        chk("rst_req", 32'(mem_req), 0);
        exp_q.push_back(22'h0);
        exp_q.push_back(22'h8000);
        exp_q.push_back(22'h0);
        rst_n = 1;
        serve(0, 16'h1234);
        serve(0, 16'h5678);
        serve(0, 16'h9abc);
        chk("init_char_ok", 32'(char_ok), 1);
        chk("init_scr_ok", 32'(scr_ok), 1);
        chk("init_obj_ok", 32'(obj_ok), 1);
        chk("init_char_data", 32'(char_data), 32'h34);
        chk("init_scr_data", 32'(scr_data), 32'h5678);
        chk("init_obj_data", 32'(obj_data), 32'h9abc);
        // byte select change without refetch
        char_addr = 15'h0010;
        exp_q.push_back(22'h8);
        serve(0, 16'ha55a);
        chk("char10_ok", 32'(char_ok), 1);
        chk("char10_data", 32'(char_data), 32'h5a);
        char_addr = 15'h0011;
        #1;
        chk("char11_ok", 32'(char_ok), 1);
        chk("char11_data", 32'(char_data), 32'ha5);
        repeat (3) begin
            @(negedge clk);
            chk("char11_noreq", 32'(mem_req), 0);
        end
        // scroll with offset, two-cycle latency
        scr_addr = 17'h00100;
        exp_q.push_back(22'h8100);
        #1;
        chk("scr_ok_drop", 32'(scr_ok), 0);
        @(negedge clk);
        chk("scr_req", 32'(mem_req), 1);
        chk("scr_addr", 32'(mem_addr), 32'h8100);
        mem_ack = 1;
        mem_rdy = 1;
        mem_dout = 16'hbeef;
        @(negedge clk);
        mem_ack = 0;
        mem_rdy = 0;
        chk("scr_ok", 32'(scr_ok), 1);
        chk("scr_data", 32'(scr_data), 32'hbeef);
        // object address changes while waiting for data
        obj_addr = 18'h10;
        exp_q.push_back(22'h10);
        wait_req();
        mem_ack = 1;
        @(negedge clk);
        mem_ack = 0;
        obj_addr = 18'h20;
        exp_q.push_back(22'h20);
        @(negedge clk);
        mem_rdy = 1;
        mem_dout = 16'h1111;
        @(negedge clk);
        mem_rdy = 0;
        chk("obj_stale_ok", 32'(obj_ok), 0);
        chk("obj_stale_noreq", 32'(mem_req), 0);
        @(negedge clk);
        chk("obj_rereq", 32'(mem_req), 1);
        chk("obj_rereq_addr", 32'(mem_addr), 32'h20);
        serve(0, 16'h2222);
        chk("obj20_ok", 32'(obj_ok), 1);
        chk("obj20_data", 32'(obj_data), 32'h2222);
        // char and obj pending together, char served first with a 5-cycle ack delay
        char_addr = 15'h0040;
        obj_addr = 18'h30;
        exp_q.push_back(22'h20);
        exp_q.push_back(22'h30);
        serve(5, 16'h7788);
        chk("pair_obj_ok_mid", 32'(obj_ok), 0);
        serve(0, 16'h99aa);
        chk("pair_char_ok", 32'(char_ok), 1);
        chk("pair_char_data", 32'(char_data), 32'h88);
        chk("pair_obj_ok", 32'(obj_ok), 1);
        chk("pair_obj_data", 32'(obj_data), 32'h99aa);
        // reset while in WAIT; the late rdy must be ignored
        scr_addr = 17'h00200;
        exp_q.push_back(22'h8200);
        wait_req();
        mem_ack = 1;
        @(negedge clk);
        mem_ack = 0;
        rst_n = 0;
        #1;
        chk("wrst_req", 32'(mem_req), 0);
        chk("wrst_char_ok", 32'(char_ok), 0);
        chk("wrst_scr_ok", 32'(scr_ok), 0);
        chk("wrst_obj_ok", 32'(obj_ok), 0);
        @(negedge clk);
        mem_rdy = 1;
        mem_dout = 16'hdead;
        @(negedge clk);
        mem_rdy = 0;
        chk("wrst_late_scr_ok", 32'(scr_ok), 0);
        chk("wrst_late_req", 32'(mem_req), 0);
        exp_q.push_back(22'h20);
        exp_q.push_back(22'h8200);
        exp_q.push_back(22'h30);
        rst_n = 1;
        serve(0, 16'h0102);
        serve(0, 16'h0304);
        serve(0, 16'h0506);
        chk("rest_char_data", 32'(char_data), 32'h02);
        chk("rest_scr_data", 32'(scr_data), 32'h0304);
        chk("rest_obj_data", 32'(obj_data), 32'h0506);
        chk("rest_all_ok", 32'({char_ok, scr_ok, obj_ok}), 32'h7);
        @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
